// File: rtl/pipe_ctrl_pkg.sv
// Shared types and default sizing for the single-step pipeline sequencer.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_CLR   = 2'd2,
    S_DISP  = 2'd3
  } state_t;

  localparam int CNT_W_DEF   = 8;
  localparam int DIV_W_DEF   = 26;
  localparam int RUN_DIV_DEF = 25_000_000;

endpackage

// File: rtl/step_rate_div.sv
// Free-run step divider: one-cycle tick every RUN_DIV enabled cycles.
module step_rate_div
  import pipe_ctrl_pkg::*;
#(
  parameter int DIV_W   = DIV_W_DEF,
  parameter int RUN_DIV = RUN_DIV_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [DIV_W-1:0] LAST = DIV_W'(RUN_DIV - 1);

  logic [DIV_W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_step_ctrl.sv
// Step/clear sequencer for the single-step pipeline with display handshake.
// Optional run-mode breakpoint halting is enabled by defining PIPE_STEP_BP_EN.
module pipe_step_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DIV_W   = DIV_W_DEF,
  parameter int RUN_DIV = RUN_DIV_DEF
) (
  input  logic             CCLK,
  input  logic             rst_n,
  input  logic             step_btn,
  input  logic             clr_btn,
  input  logic             run_sw,
  input  logic             bp_en,
  input  logic [31:0]      bp_pc,
  input  logic [31:0]      if_pc,
  input  logic             disp_ack,
  output logic             pipe_ce,
  output logic             pipe_clr,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic             disp_req,
  output logic             halted,
  output logic             busy
);

  state_t state, state_n;
  logic   step_q, clr_q;
  logic   step_edge, clr_edge;
  logic   pend_step, pend_clr, pend_step_n, pend_clr_n;
  logic   tick, div_en, div_clr;
  logic   tick_halt, bp_hit;

  assign step_edge = step_btn & ~step_q;
  assign clr_edge  = clr_btn & ~clr_q;
  assign busy      = (state != S_IDLE);
  assign div_clr   = ~run_sw;

`ifdef PIPE_STEP_BP_EN
  logic halted_q;

  assign tick_halt = bp_en && (if_pc == bp_pc);
  assign halted    = halted_q;
  assign div_en    = run_sw & ~halted_q;

  always_ff @(posedge CCLK or negedge rst_n) begin
    if (!rst_n) begin
      halted_q <= 1'b0;
    end else if (!run_sw || pipe_clr) begin
      halted_q <= 1'b0;
    end else if (bp_hit) begin
      halted_q <= 1'b1;
    end
  end
`else
  logic unused_bp;

  assign tick_halt = 1'b0;
  assign halted    = 1'b0;
  assign div_en    = run_sw;
  assign unused_bp = ^{bp_en, bp_pc, if_pc, bp_hit};
`endif

  step_rate_div #(
    .DIV_W   (DIV_W),
    .RUN_DIV (RUN_DIV)
  ) u_div (
    .clk   (CCLK),
    .rst_n (rst_n),
    .en    (div_en),
    .clr   (div_clr),
    .tick  (tick)
  );

  always_ff @(posedge CCLK or negedge rst_n) begin
    if (!rst_n) begin
      step_q    <= 1'b0;
      clr_q     <= 1'b0;
      state     <= S_IDLE;
      pend_step <= 1'b0;
      pend_clr  <= 1'b0;
    end else begin
      step_q    <= step_btn;
      clr_q     <= clr_btn;
      state     <= state_n;
      pend_step <= pend_step_n;
      pend_clr  <= pend_clr_n;
    end
  end

  always_comb begin
    state_n     = state;
    pend_step_n = pend_step;
    pend_clr_n  = pend_clr;
    bp_hit      = 1'b0;
    case (state)
      S_IDLE: begin
        if (clr_edge) begin
          state_n = S_CLR;
        end else if (step_edge) begin
          state_n = S_PULSE;
        end else if (tick) begin
          if (tick_halt) bp_hit = 1'b1;
          else           state_n = S_PULSE;
        end
      end
      S_PULSE: state_n = S_DISP;
      S_CLR:   state_n = S_DISP;
      S_DISP: begin
        if (disp_ack) begin
          if (pend_clr) begin
            state_n    = S_CLR;
            pend_clr_n = 1'b0;
          end else if (pend_step) begin
            state_n     = S_PULSE;
            pend_step_n = 1'b0;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
    // Edges landing while busy are remembered one-deep; a clear in the same cycle swallows the step.
    if (state != S_IDLE) begin
      if (clr_edge)       pend_clr_n  = 1'b1;
      else if (step_edge) pend_step_n = 1'b1;
    end
  end

  // Outputs are registered from the current state, so each trails the FSM by one cycle.
  always_ff @(posedge CCLK or negedge rst_n) begin
    if (!rst_n) begin
      pipe_ce  <= 1'b0;
      pipe_clr <= 1'b0;
      disp_req <= 1'b0;
      cyc_cnt  <= '0;
    end else begin
      pipe_ce  <= (state == S_PULSE);
      pipe_clr <= (state == S_CLR);
      disp_req <= (state == S_DISP);
      if (pipe_clr)     cyc_cnt <= '0;
      else if (pipe_ce) cyc_cnt <= cyc_cnt + 1'b1;
    end
  end

endmodule
